// File: rtl/key_event_encoder.sv
// Seven-button front end: 2-FF sync, per-key debounce, press-edge detect, one-hot priority encode.
// Define KEY_PENDING_EN to queue simultaneous presses instead of discarding them.
module key_event_encoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20,
   parameter bit          ACTIVE_LOW      = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] keys_raw,
   output logic [6:0] key_code,
   output logic       key_valid,
   output logic [6:0] key_state,
   output logic       key_drop
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [6:0]       key_norm;
   logic [6:0]       sync1_q, sync2_q;
   logic [6:0]       stable_q, stable_d;
   logic [6:0]       prev_q;
   logic [CNT_W-1:0] cnt_q [7];
   logic [CNT_W-1:0] cnt_d [7];
   logic [6:0]       new_ev, req, grant;
   logic [6:0]       code_q;
   logic             valid_q;

   assign key_norm = ACTIVE_LOW ? ~keys_raw : keys_raw;

   always_comb begin
      for (int unsigned i = 0; i < 7; i++) begin
         stable_d[i] = stable_q[i];
         cnt_d[i]    = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) stable_d[i] = sync2_q[i];
            else                      cnt_d[i]    = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   assign new_ev = stable_q & ~prev_q;

`ifdef KEY_PENDING_EN
   logic [6:0] pend_q;
   assign req = pend_q | new_ev;
`else
   logic drop_q;
   assign req = new_ev;
`endif

   // Ascending scan: the last set bit seen (highest index) wins.
   always_comb begin
      grant = '0;
      for (int unsigned i = 0; i < 7; i++) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         prev_q   <= '0;
         code_q   <= '0;
         valid_q  <= 1'b0;
         for (int unsigned i = 0; i < 7; i++) cnt_q[i] <= '0;
`ifdef KEY_PENDING_EN
         pend_q   <= '0;
`else
         drop_q   <= 1'b0;
`endif
      end else begin
         sync1_q  <= key_norm;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         prev_q   <= stable_q;
         code_q   <= grant;
         valid_q  <= |grant;
         for (int unsigned i = 0; i < 7; i++) cnt_q[i] <= cnt_d[i];
`ifdef KEY_PENDING_EN
         pend_q   <= req & ~grant;
`else
         drop_q   <= |(new_ev & ~grant);
`endif
      end
   end

   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign key_state = stable_q;
`ifdef KEY_PENDING_EN
   assign key_drop  = 1'b0;
`else
   assign key_drop  = drop_q;
`endif

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder with an expected-event queue checked by a monitor.
module tb_key_event_encoder;

   typedef struct packed {
      logic [31:0] cyc;
      logic        valid;
      logic [6:0]  code;
      logic        drop;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] keys_raw  = 7'h00;
   logic [6:0] keys_raw2 = 7'h7F;
   logic [6:0] key_code, key_state, key_code2, key_state2;
   logic       key_valid, key_drop, key_valid2, key_drop2;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] cyc   = 0;
   ev_t         q  [$];
   ev_t         q2 [$];

   key_event_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst(rst), .keys_raw(keys_raw), .key_code(key_code),
      .key_valid(key_valid), .key_state(key_state), .key_drop(key_drop));

   key_event_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1'b1)) dut2 (
      .clk(clk), .rst(rst), .keys_raw(keys_raw2), .key_code(key_code2),
      .key_valid(key_valid2), .key_state(key_state2), .key_drop(key_drop2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] at, input logic [6:0] code, input logic drop);
      q.push_back('{cyc: at, valid: 1'b1, code: code, drop: drop});
   endtask

   always @(negedge clk) begin
      if (!rst && (key_valid || key_drop || key_code != 7'h00)) begin
         ev_t o, e;
         o = '{cyc: cyc, valid: key_valid, code: key_code, drop: key_drop};
         tests++;
         if (q.size() == 0) begin
            fails++;
            $error("FAIL unexpected_event observed=%h expected=none", o);
         end else begin
            e = q.pop_front();
            assert (o === e) else begin
               fails++;
               $error("FAIL event observed=%h expected=%h", o, e);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && (key_valid2 || key_drop2 || key_code2 != 7'h00)) begin
         ev_t o, e;
         o = '{cyc: cyc, valid: key_valid2, code: key_code2, drop: key_drop2};
         tests++;
         if (q2.size() == 0) begin
            fails++;
            $error("FAIL unexpected_event_al observed=%h expected=none", o);
         end else begin
            e = q2.pop_front();
            assert (o === e) else begin
               fails++;
               $error("FAIL event_al observed=%h expected=%h", o, e);
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_code",   32'(key_code),   32'h0);
      chk("rst_valid",  32'(key_valid),  32'h0);
      chk("rst_state",  32'(key_state),  32'h0);
      chk("rst_drop",   32'(key_drop),   32'h0);
      chk("rst_code2",  32'(key_code2),  32'h0);
      chk("rst_state2", 32'(key_state2), 32'h0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // 1: bounce on START, then hold
      keys_raw[6] = 1'b1;
      @(negedge clk) keys_raw[6] = 1'b0;
      @(negedge clk) keys_raw[6] = 1'b1;
      push(cyc + 7, 7'b1000000, 1'b0);
      repeat (30) @(negedge clk);
      chk("t1_state", 32'(key_state), 32'h40);

      // 2: glitch shorter than the debounce window
      keys_raw[3] = 1'b1;
      repeat (3) @(negedge clk);
      keys_raw[3] = 1'b0;
      repeat (20) @(negedge clk);
      chk("t2_state", 32'(key_state), 32'h40);

      // 3: simultaneous STOP1 + STOP2
      keys_raw[5:4] = 2'b11;
`ifdef KEY_PENDING_EN
      push(cyc + 7, 7'b0100000, 1'b0);
      push(cyc + 8, 7'b0010000, 1'b0);
`else
      push(cyc + 7, 7'b0100000, 1'b1);
`endif
      repeat (20) @(negedge clk);
      chk("t3_state", 32'(key_state), 32'h70);
      keys_raw[5:4] = 2'b00;
      repeat (20) @(negedge clk);
      chk("t3_release", 32'(key_state), 32'h40);

      // 4: hold, release, re-press MIN
      keys_raw[2] = 1'b1;
      push(cyc + 7, 7'b0000100, 1'b0);
      repeat (100) @(negedge clk);
      keys_raw[2] = 1'b0;
      repeat (20) @(negedge clk);
      chk("t4_released", 32'(key_state), 32'h40);
      keys_raw[2] = 1'b1;
      push(cyc + 7, 7'b0000100, 1'b0);
      repeat (20) @(negedge clk);
      keys_raw[2] = 1'b0;
      repeat (20) @(negedge clk);

      // 5: async reset while P1 debounce counter is at 2 (START release also in flight)
      keys_raw = 7'b0000010;
      repeat (4) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("t5_rst_state", 32'(key_state), 32'h0);
      chk("t5_rst_code",  32'(key_code),  32'h0);
      chk("t5_rst_valid", 32'(key_valid), 32'h0);
      @(negedge clk) rst = 1'b0;
      push(cyc + 7, 7'b0000010, 1'b0);
      repeat (20) @(negedge clk);
      chk("t5_state", 32'(key_state), 32'h02);

      // 6: active-low instance, P2 pressed
      chk("t6_idle_state", 32'(key_state2), 32'h0);
      keys_raw2[0] = 1'b0;
      q2.push_back('{cyc: cyc + 7, valid: 1'b1, code: 7'b0000001, drop: 1'b0});
      repeat (20) @(negedge clk);
      chk("t6_state", 32'(key_state2), 32'h01);

      chk("queue_drained",    32'(q.size()),  32'h0);
      chk("queue_drained_al", 32'(q2.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
